// File: rtl/tcm_dport_arbiter.sv
// Two-master round-robin arbiter for the TCM data port. A master-ID FIFO records
// the owner of every accepted request so in-order responses return to the issuer.
module tcm_dport_arbiter #(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_wr_i,
  input  logic        m0_rd_i,
  input  logic [3:0]  m0_wr_i,
  input  logic        m0_cacheable_i,
  input  logic [10:0] m0_req_tag_i,
  output logic        m0_accept_o,
  output logic        m0_ack_o,
  output logic [31:0] m0_data_rd_o,
  output logic        m0_error_o,
  output logic [10:0] m0_resp_tag_o,

  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_wr_i,
  input  logic        m1_rd_i,
  input  logic [3:0]  m1_wr_i,
  input  logic        m1_cacheable_i,
  input  logic [10:0] m1_req_tag_i,
  output logic        m1_accept_o,
  output logic        m1_ack_o,
  output logic [31:0] m1_data_rd_o,
  output logic        m1_error_o,
  output logic [10:0] m1_resp_tag_o,

  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_wr_o,
  output logic        s_rd_o,
  output logic [3:0]  s_wr_o,
  output logic        s_cacheable_o,
  output logic [10:0] s_req_tag_o,
  input  logic        s_accept_i,
  input  logic        s_ack_i,
  input  logic [31:0] s_data_rd_i,
  input  logic        s_error_i,
  input  logic [10:0] s_resp_tag_i,

  output logic        busy_o,
  output logic        orphan_ack_o
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic        rd;
    logic [3:0]  wr;
    logic        cacheable;
    logic [10:0] tag;
  } req_t;

  typedef struct packed {
    logic        ack;
    logic [31:0] data_rd;
    logic        error;
    logic [10:0] tag;
  } resp_t;

  // prio_q == 0 gives master 0 priority on a tie, 1 gives master 1.
  logic                   prio_q, prio_d;
  logic                   orphan_q, orphan_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [OUTSTANDING-1:0] fifo_q, fifo_d;

  req_t  m0_req, m1_req, s_req;
  resp_t s_resp, m0_resp, m1_resp;
  logic  req0, req1, grant0, grant1;
  logic  full, empty, issue, push, push_id, pop, head_id;

  // NOTE: every signal assigned in this block gets a default first, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    m0_req  = '{m0_addr_i, m0_data_wr_i, m0_rd_i, m0_wr_i, m0_cacheable_i, m0_req_tag_i};
    m1_req  = '{m1_addr_i, m1_data_wr_i, m1_rd_i, m1_wr_i, m1_cacheable_i, m1_req_tag_i};
    s_resp  = '{1'b1, s_data_rd_i, s_error_i, s_resp_tag_i};

    req0    = m0_rd_i | (|m0_wr_i);
    req1    = m1_rd_i | (|m1_wr_i);
    grant0  = req0 & (~req1 | ~prio_q);
    grant1  = req1 & (~req0 |  prio_q);

    full    = (count_q == FULL_CNT);
    empty   = (count_q == '0);
    issue   = (grant0 | grant1) & ~full & ~rst_i;

    s_req   = '0;
    if (issue) s_req = grant1 ? m1_req : m0_req;

    m0_accept_o = grant0 & s_accept_i & issue;
    m1_accept_o = grant1 & s_accept_i & issue;
    push        = m0_accept_o | m1_accept_o;
    push_id     = m1_accept_o;

    // Response path is purely combinational: the FIFO head selects the owner.
    head_id = fifo_q[rd_ptr_q];
    pop     = s_ack_i & ~empty & ~rst_i;
    m0_resp = '0;
    m1_resp = '0;
    if (pop && !head_id) m0_resp = s_resp;
    if (pop &&  head_id) m1_resp = s_resp;

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    prio_d   = push ? ~push_id : prio_q;
    orphan_d = orphan_q | (s_ack_i & empty & ~rst_i);
    fifo_d   = fifo_q;
    if (push) fifo_d[wr_ptr_q] = push_id;
  end

  assign s_addr_o      = s_req.addr;
  assign s_data_wr_o   = s_req.data_wr;
  assign s_rd_o        = s_req.rd;
  assign s_wr_o        = s_req.wr;
  assign s_cacheable_o = s_req.cacheable;
  assign s_req_tag_o   = s_req.tag;

  assign m0_ack_o      = m0_resp.ack;
  assign m0_data_rd_o  = m0_resp.data_rd;
  assign m0_error_o    = m0_resp.error;
  assign m0_resp_tag_o = m0_resp.tag;
  assign m1_ack_o      = m1_resp.ack;
  assign m1_data_rd_o  = m1_resp.data_rd;
  assign m1_error_o    = m1_resp.error;
  assign m1_resp_tag_o = m1_resp.tag;

  assign busy_o        = ~empty;
  assign orphan_ack_o  = orphan_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q   <= 1'b0;
      orphan_q <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      prio_q   <= prio_d;
      orphan_q <= orphan_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the ID storage has no reset; an entry is only read once count_q marks
  // it valid, so clearing it would add reset fan-out for no behavioural gain.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_tcm_dport_arbiter.sv
// Self-checking bench for tcm_dport_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a queue model.
module tb_tcm_dport_arbiter;

  localparam int OUT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m_addr[2], m_wdata[2];
  logic        m_rd[2], m_cache[2];
  logic [3:0]  m_wr[2];
  logic [10:0] m_tag[2];
  logic        m_accept[2], m_ack[2], m_err[2];
  logic [31:0] m_rdata[2];
  logic [10:0] m_rtag[2];
  logic [31:0] s_addr_o, s_data_wr_o, s_data_rd_i;
  logic        s_rd_o, s_cacheable_o, s_accept_i, s_ack_i, s_error_i;
  logic [3:0]  s_wr_o;
  logic [10:0] s_req_tag_o, s_resp_tag_i;
  logic        busy_o, orphan_ack_o;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: list of owners of outstanding requests, tie priority, sticky flag.
  int q[$];
  int prio_m;
  bit orphan_m;
  int acc_g;
  int hd;
  bit orph_hit;

  tcm_dport_arbiter #(.OUTSTANDING(OUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_addr_i(m_addr[0]), .m0_data_wr_i(m_wdata[0]), .m0_rd_i(m_rd[0]), .m0_wr_i(m_wr[0]),
    .m0_cacheable_i(m_cache[0]), .m0_req_tag_i(m_tag[0]), .m0_accept_o(m_accept[0]),
    .m0_ack_o(m_ack[0]), .m0_data_rd_o(m_rdata[0]), .m0_error_o(m_err[0]), .m0_resp_tag_o(m_rtag[0]),
    .m1_addr_i(m_addr[1]), .m1_data_wr_i(m_wdata[1]), .m1_rd_i(m_rd[1]), .m1_wr_i(m_wr[1]),
    .m1_cacheable_i(m_cache[1]), .m1_req_tag_i(m_tag[1]), .m1_accept_o(m_accept[1]),
    .m1_ack_o(m_ack[1]), .m1_data_rd_o(m_rdata[1]), .m1_error_o(m_err[1]), .m1_resp_tag_o(m_rtag[1]),
    .s_addr_o(s_addr_o), .s_data_wr_o(s_data_wr_o), .s_rd_o(s_rd_o), .s_wr_o(s_wr_o),
    .s_cacheable_o(s_cacheable_o), .s_req_tag_o(s_req_tag_o), .s_accept_i(s_accept_i),
    .s_ack_i(s_ack_i), .s_data_rd_i(s_data_rd_i), .s_error_i(s_error_i), .s_resp_tag_i(s_resp_tag_i),
    .busy_o(busy_o), .orphan_ack_o(orphan_ack_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      m_addr[n] = '0; m_wdata[n] = '0; m_rd[n] = 1'b0; m_wr[n] = '0;
      m_cache[n] = 1'b0; m_tag[n] = '0;
    end
    s_accept_i = 1'b0; s_ack_i = 1'b0; s_data_rd_i = '0; s_error_i = 1'b0; s_resp_tag_i = '0;
  endtask

  task automatic set_req(input int n, input bit rd, input logic [3:0] wr,
                         input logic [31:0] addr, input logic [10:0] tag);
    m_rd[n] = rd; m_wr[n] = wr; m_addr[n] = addr; m_tag[n] = tag;
    m_wdata[n] = $urandom; m_cache[n] = 1'($urandom_range(0, 1));
  endtask

  // Settle inputs, derive required outputs from the rules, compare every output.
  task automatic eval_cycle();
    bit r0, r1, full, issue;
    int g;
    int src;
    #1;
    r0 = m_rd[0] | (|m_wr[0]);
    r1 = m_rd[1] | (|m_wr[1]);
    g = -1;
    if (r0 && r1) g = prio_m;
    else if (r0)  g = 0;
    else if (r1)  g = 1;
    full     = (q.size() == OUT);
    issue    = (g >= 0) && !full && !rst_i;
    src      = issue ? g : 0;
    acc_g    = (issue && s_accept_i) ? g : -1;
    hd       = (!rst_i && s_ack_i && q.size() > 0) ? q[0] : -1;
    orph_hit = !rst_i && s_ack_i && q.size() == 0;

    check("s_addr",    s_addr_o,      issue ? m_addr[src]  : 32'h0);
    check("s_data_wr", s_data_wr_o,   issue ? m_wdata[src] : 32'h0);
    check("s_rd",      s_rd_o,        issue ? m_rd[src]    : 1'b0);
    check("s_wr",      s_wr_o,        issue ? m_wr[src]    : 4'h0);
    check("s_cache",   s_cacheable_o, issue ? m_cache[src] : 1'b0);
    check("s_tag",     s_req_tag_o,   issue ? m_tag[src]   : 11'h0);
    for (int n = 0; n < 2; n++) begin
      check($sformatf("accept%0d", n), m_accept[n], acc_g == n);
      check($sformatf("ack%0d", n),    m_ack[n],    hd == n);
      check($sformatf("rdata%0d", n),  m_rdata[n],  (hd == n) ? s_data_rd_i  : 32'h0);
      check($sformatf("err%0d", n),    m_err[n],    (hd == n) ? s_error_i    : 1'b0);
      check($sformatf("rtag%0d", n),   m_rtag[n],   (hd == n) ? s_resp_tag_i : 11'h0);
    end
    check("busy",   busy_o,       q.size() != 0);
    check("orphan", orphan_ack_o, orphan_m);
  endtask

  task automatic advance();
    @(posedge clk_i);
    if (!rst_i) begin
      if (hd >= 0) void'(q.pop_front());
      if (orph_hit) orphan_m = 1'b1;
      if (acc_g >= 0) begin
        q.push_back(acc_g);
        prio_m = 1 - acc_g;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic cyc();
    eval_cycle();
    advance();
  endtask

  task automatic model_reset();
    q.delete();
    prio_m   = 0;
    orphan_m = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    model_reset();
    idle_inputs();
    eval_cycle();
    advance();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk_i);
    do_reset();

    // Single read from master 0, one-cycle TCM.
    check("t1_busy_reset", busy_o, 1'b0);
    set_req(0, 1'b1, 4'h0, 32'h8000_0000, 11'h05);
    s_accept_i = 1'b1;
    eval_cycle();
    check("t1_m0_accept", m_accept[0], 1'b1);
    check("t1_s_addr", s_addr_o, 32'h8000_0000);
    advance();
    idle_inputs();
    s_ack_i = 1'b1; s_data_rd_i = 32'hDEAD_BEEF; s_resp_tag_i = 11'h05;
    eval_cycle();
    check("t1_m0_ack", m_ack[0], 1'b1);
    check("t1_m0_data", m_rdata[0], 32'hDEAD_BEEF);
    check("t1_m1_ack", m_ack[1], 1'b0);
    advance();

    // Both masters request continuously: grants alternate, acks follow one cycle later.
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      idle_inputs();
      if (i < 8) begin
        set_req(0, 1'b1, 4'h0, 32'h1000 + i, 11'(32'h100 + i));
        set_req(1, 1'b0, 4'hF, 32'h2000 + i, 11'(32'h200 + i));
        s_accept_i = 1'b1;
      end
      if (i > 0) begin
        s_ack_i = 1'b1;
        s_data_rd_i = $urandom;
        s_resp_tag_i = ((i - 1) % 2 == 0) ? 11'(32'h100 + i - 1) : 11'(32'h200 + i - 1);
      end
      eval_cycle();
      if (i < 8) begin
        check($sformatf("t2_grant%0d", i), m_accept[i % 2], 1'b1);
        check($sformatf("t2_nogrant%0d", i), m_accept[(i + 1) % 2], 1'b0);
      end
      if (i > 0) begin
        check($sformatf("t2_ack%0d", i - 1), m_ack[(i - 1) % 2], 1'b1);
        check($sformatf("t2_rtag%0d", i - 1), m_rtag[(i - 1) % 2],
              ((i - 1) % 2 == 0) ? 11'(32'h100 + i - 1) : 11'(32'h200 + i - 1));
      end
      advance();
    end

    // FIFO fills at four; a pop while full frees the slot only on the next cycle.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      set_req(1, 1'b0, 4'b0011, 32'h40 + 4 * i, 11'(i));
      s_accept_i = 1'b1;
      s_ack_i = (i == 5);
      eval_cycle();
      if (i < 4) check($sformatf("t3_acc%0d", i), m_accept[1], 1'b1);
      if (i == 4) begin
        check("t3_full_acc", m_accept[1], 1'b0);
        check("t3_full_swr", s_wr_o, 4'h0);
        check("t3_full_busy", busy_o, 1'b1);
      end
      if (i == 5) begin
        check("t3_pop_acc", m_accept[1], 1'b0);
        check("t3_pop_ack", m_ack[1], 1'b1);
      end
      if (i == 6) check("t3_after_pop_acc", m_accept[1], 1'b1);
      advance();
    end
    idle_inputs();
    s_ack_i = 1'b1;
    repeat (4) cyc();
    s_ack_i = 1'b0;
    eval_cycle();
    check("t3_drained", busy_o, 1'b0);
    advance();

    // Simultaneous push and pop at count 2.
    do_reset();
    idle_inputs(); set_req(1, 1'b0, 4'h1, 32'h10, 11'h1); s_accept_i = 1'b1; cyc();
    idle_inputs(); set_req(0, 1'b1, 4'h0, 32'h20, 11'h2); s_accept_i = 1'b1; cyc();
    idle_inputs(); set_req(0, 1'b1, 4'h0, 32'h30, 11'h3); s_accept_i = 1'b1; s_ack_i = 1'b1;
    eval_cycle();
    check("t4_pp_acc0", m_accept[0], 1'b1);
    check("t4_pp_ack1", m_ack[1], 1'b1);
    advance();
    idle_inputs(); s_ack_i = 1'b1;
    eval_cycle();
    check("t4_older_ack0", m_ack[0], 1'b1);
    check("t4_older_ack1", m_ack[1], 1'b0);
    advance();
    eval_cycle();
    check("t4_last_ack0", m_ack[0], 1'b1);
    check("t4_last_busy", busy_o, 1'b1);
    advance();
    s_ack_i = 1'b0;
    eval_cycle();
    check("t4_count2_empty", busy_o, 1'b0);
    advance();

    // Orphan ack after reset.
    do_reset();
    s_ack_i = 1'b1; s_data_rd_i = 32'h1234_5678;
    eval_cycle();
    check("t5_no_ack0", m_ack[0], 1'b0);
    check("t5_no_ack1", m_ack[1], 1'b0);
    advance();
    s_ack_i = 1'b0;
    eval_cycle();
    check("t5_orphan", orphan_ack_o, 1'b1);
    advance();
    repeat (3) cyc();
    check("t5_orphan_sticky", orphan_ack_o, 1'b1);

    // Asynchronous reset with three outstanding requests.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      set_req(0, 1'b1, 4'h0, 32'h100, 11'h7);
      set_req(1, 1'b0, 4'h8, 32'h200, 11'h9);
      s_accept_i = 1'b1;
      cyc();
    end
    s_ack_i = 1'b1;
    eval_cycle();
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    check("t6_rst_busy", busy_o, 1'b0);
    check("t6_rst_acc0", m_accept[0], 1'b0);
    check("t6_rst_acc1", m_accept[1], 1'b0);
    check("t6_rst_ack0", m_ack[0], 1'b0);
    check("t6_rst_srd", s_rd_o, 1'b0);
    check("t6_rst_swr", s_wr_o, 4'h0);
    check("t6_rst_saddr", s_addr_o, 32'h0);
    eval_cycle();
    advance();
    rst_i = 1'b0;
    s_ack_i = 1'b0;
    eval_cycle();
    check("t6_rel_acc0", m_accept[0], 1'b1);
    check("t6_rel_acc1", m_accept[1], 1'b0);
    check("t6_rel_busy", busy_o, 1'b0);
    advance();

    // Randomized traffic; a refused master holds its request.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      for (int n = 0; n < 2; n++) begin
        bit pending;
        pending = (m_rd[n] || (|m_wr[n])) && (acc_g != n);
        if (!pending) begin
          case ($urandom_range(0, 3))
            0: set_req(n, 1'b0, 4'h0, '0, '0);
            1: set_req(n, 1'b1, 4'h0, $urandom, 11'($urandom));
            default: set_req(n, 1'b0, 4'($urandom_range(1, 15)), $urandom, 11'($urandom));
          endcase
        end
      end
      s_accept_i   = ($urandom_range(0, 3) != 0);
      s_ack_i      = ($urandom_range(0, 1) == 1);
      s_data_rd_i  = $urandom;
      s_error_i    = ($urandom_range(0, 7) == 0);
      s_resp_tag_i = 11'($urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
